// File: rtl/interconn_pkg.sv
// Default sizing shared by the MVU crossbar and the MVU top level.
package interconn_pkg;

    localparam int N_MVU  = 8;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 15;

endpackage

// File: rtl/interconn_port.sv
// One crossbar destination: fixed-priority arbitration over the sources
// targeting it, AND-OR data selection and the registered outputs.
module interconn_port
    import interconn_pkg::*;
#(
    parameter int N     = N_MVU,
    parameter int W     = DATA_W,
    parameter int BADDR = ADDR_W
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [N-1:0]       req,
    input  logic [N*BADDR-1:0] send_addr,
    input  logic [N*W-1:0]     send_word,
    output logic [N-1:0]       recv_from,
    output logic               recv_en,
    output logic [BADDR-1:0]   recv_addr,
    output logic [W-1:0]       recv_word
);

    logic [N-1:0]     grant;
    logic [BADDR-1:0] addr_mux;
    logic [W-1:0]     word_mux;

    // Isolate the lowest set request bit: the lowest source index wins.
    assign grant = req & (~req + N'(1));

    always_comb begin
        addr_mux = '0;
        word_mux = '0;
        for (int i = 0; i < N; i++) begin
            addr_mux = addr_mux | (send_addr[i*BADDR +: BADDR] & {BADDR{grant[i]}});
            word_mux = word_mux | (send_word[i*W +: W] & {W{grant[i]}});
        end
    end

    // With no request the grant is zero, so every slice registers as 0.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            recv_en   <= 1'b0;
            recv_from <= '0;
            recv_addr <= '0;
            recv_word <= '0;
        end else begin
            recv_en   <= |req;
            recv_from <= grant;
            recv_addr <= addr_mux;
            recv_word <= word_mux;
        end
    end

endmodule

// File: rtl/interconn.sv
// N-port MVU write crossbar: transposes the source requests into
// per-destination request vectors and instantiates one port per destination.
module interconn
    import interconn_pkg::*;
#(
    parameter int N     = N_MVU,
    parameter int W     = DATA_W,
    parameter int BADDR = ADDR_W
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [N*N-1:0]     send_to,
    input  logic [N-1:0]       send_en,
    input  logic [N*BADDR-1:0] send_addr,
    input  logic [N*W-1:0]     send_word,
    output logic [N*N-1:0]     recv_from,
    output logic [N-1:0]       recv_en,
    output logic [N*BADDR-1:0] recv_addr,
    output logic [N*W-1:0]     recv_word
);

    logic [N-1:0][N-1:0] req;

    for (genvar j = 0; j < N; j++) begin : g_dest
        for (genvar i = 0; i < N; i++) begin : g_src
            assign req[j][i] = send_en[i] & send_to[i*N + j];
        end

        interconn_port #(
            .N     (N),
            .W     (W),
            .BADDR (BADDR)
        ) u_port (
            .clk       (clk),
            .clr_n     (clr_n),
            .req       (req[j]),
            .send_addr (send_addr),
            .send_word (send_word),
            .recv_from (recv_from[j*N +: N]),
            .recv_en   (recv_en[j]),
            .recv_addr (recv_addr[j*BADDR +: BADDR]),
            .recv_word (recv_word[j*W +: W])
        );
    end

endmodule

// File: tb/tb_interconn.sv
// Self-checking bench for the MVU crossbar: directed scenarios plus random
// traffic checked against a per-destination priority model.
module tb_interconn;

    localparam int N     = 8;
    localparam int W     = 64;
    localparam int BADDR = 15;

    logic               clk = 1'b0;
    logic               clr_n;
    logic [N*N-1:0]     send_to;
    logic [N-1:0]       send_en;
    logic [N*BADDR-1:0] send_addr;
    logic [N*W-1:0]     send_word;
    logic [N*N-1:0]     recv_from;
    logic [N-1:0]       recv_en;
    logic [N*BADDR-1:0] recv_addr;
    logic [N*W-1:0]     recv_word;

    logic [N*N-1:0]     exp_from;
    logic [N-1:0]       exp_en;
    logic [N*BADDR-1:0] exp_addr;
    logic [N*W-1:0]     exp_word;

    int compared   = 0;
    int mismatched = 0;

    interconn dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .send_to   (send_to),
        .send_en   (send_en),
        .send_addr (send_addr),
        .send_word (send_word),
        .recv_from (recv_from),
        .recv_en   (recv_en),
        .recv_addr (recv_addr),
        .recv_word (recv_word)
    );

    always #5 clk = ~clk;

    task automatic randomize_data();
        for (int k = 0; k < N*BADDR; k += 32) send_addr[k +: 32] = $urandom;
        for (int k = 0; k < N*W; k += 32)     send_word[k +: 32] = $urandom;
    endtask

    task automatic clear_inputs();
        send_en   = '0;
        send_to   = '0;
        send_addr = '0;
        send_word = '0;
    endtask

    // Reference: each destination takes the lowest-numbered enabled source aimed at it.
    task automatic model();
        exp_en   = '0;
        exp_from = '0;
        exp_addr = '0;
        exp_word = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (!exp_en[j] && send_en[i] && send_to[i*N + j]) begin
                    exp_en[j]                   = 1'b1;
                    exp_from[j*N + i]           = 1'b1;
                    exp_addr[j*BADDR +: BADDR]  = send_addr[i*BADDR +: BADDR];
                    exp_word[j*W +: W]          = send_word[i*W +: W];
                end
            end
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (10) begin
            send_en = N'($urandom);
            send_to = {$urandom, $urandom};
            randomize_data();
            @(negedge clk);
            compared++;
            if (recv_en !== '0 || recv_from !== '0 || recv_addr !== '0 || recv_word !== '0) begin
                mismatched++;
                $display("[TB] FAIL reset_hold: en=%h from=%h addr=%h word=%h, required all 0",
                         recv_en, recv_from, recv_addr, recv_word);
            end
        end
        clear_inputs();
        clr_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            compared++;
            if (recv_en !== '0 || recv_from !== '0 || recv_addr !== '0 || recv_word !== '0) begin
                mismatched++;
                $display("[TB] FAIL reset_release: en=%h from=%h addr=%h word=%h, required all 0",
                         recv_en, recv_from, recv_addr, recv_word);
            end
        end
    endtask

    task automatic test_one_to_one();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i == j) continue;
                clear_inputs();
                send_en                      = N'(1) << i;
                send_to                      = (N*N)'(1) << (i*N + j);
                send_addr[i*BADDR +: BADDR]  = BADDR'(7);
                send_word[i*W +: W]          = 64'hdeadbeefdeadbeef;
                exp_en   = N'(1) << j;
                exp_from = '0;
                exp_from[j*N +: N] = N'(1) << i;
                exp_addr = '0;
                exp_addr[j*BADDR +: BADDR] = BADDR'(7);
                exp_word = '0;
                exp_word[j*W +: W] = 64'hdeadbeefdeadbeef;
                @(posedge clk); #1;
                compared++;
                if (recv_en !== exp_en || recv_from !== exp_from ||
                    recv_addr !== exp_addr || recv_word !== exp_word) begin
                    mismatched++;
                    $display("[TB] FAIL pair_%0d_to_%0d: en=%h from=%h addr=%h word=%h, required en=%h from=%h addr=%h word=%h",
                             i, j, recv_en, recv_from, recv_addr, recv_word[j*W +: W],
                             exp_en, exp_from, exp_addr, exp_word[j*W +: W]);
                end
                compared++;
                if (recv_word !== exp_word) begin
                    mismatched++;
                    $display("[TB] FAIL pair_word_%0d_to_%0d: word=%h, required %h", i, j, recv_word, exp_word);
                end
            end
        end
    endtask

    task automatic test_conflict();
        clear_inputs();
        send_en                      = 8'b0010_0100;
        send_to[2*N + 3]             = 1'b1;
        send_to[5*N + 3]             = 1'b1;
        send_addr[2*BADDR +: BADDR]  = BADDR'(1);
        send_addr[5*BADDR +: BADDR]  = BADDR'(2);
        send_word[2*W +: W]          = 64'h11;
        send_word[5*W +: W]          = 64'h22;
        exp_en   = 8'b0000_1000;
        exp_from = '0;
        exp_from[3*N +: N] = 8'b0000_0100;
        exp_addr = '0;
        exp_addr[3*BADDR +: BADDR] = BADDR'(1);
        exp_word = '0;
        exp_word[3*W +: W] = 64'h11;
        @(posedge clk); #1;
        compared++;
        if (recv_en !== exp_en || recv_from !== exp_from) begin
            mismatched++;
            $display("[TB] FAIL conflict_grant: en=%h from=%h, required en=%h from=%h",
                     recv_en, recv_from, exp_en, exp_from);
        end
        compared++;
        if (recv_addr !== exp_addr || recv_word !== exp_word) begin
            mismatched++;
            $display("[TB] FAIL conflict_data: addr=%h word3=%h, required addr=%h word3=%h",
                     recv_addr, recv_word[3*W +: W], exp_addr, exp_word[3*W +: W]);
        end
    endtask

    task automatic test_multicast();
        clear_inputs();
        randomize_data();
        send_en          = 8'b0100_0001;
        send_to[0*N + 1] = 1'b1;
        send_to[0*N + 4] = 1'b1;
        send_to[6*N + 7] = 1'b1;
        exp_en   = 8'b1001_0010;
        exp_from = '0;
        exp_from[1*N +: N] = 8'b0000_0001;
        exp_from[4*N +: N] = 8'b0000_0001;
        exp_from[7*N +: N] = 8'b0100_0000;
        exp_addr = '0;
        exp_addr[1*BADDR +: BADDR] = send_addr[0 +: BADDR];
        exp_addr[4*BADDR +: BADDR] = send_addr[0 +: BADDR];
        exp_addr[7*BADDR +: BADDR] = send_addr[6*BADDR +: BADDR];
        exp_word = '0;
        exp_word[1*W +: W] = send_word[0 +: W];
        exp_word[4*W +: W] = send_word[0 +: W];
        exp_word[7*W +: W] = send_word[6*W +: W];
        @(posedge clk); #1;
        compared++;
        if (recv_en !== exp_en || recv_from !== exp_from) begin
            mismatched++;
            $display("[TB] FAIL multicast_grant: en=%h from=%h, required en=%h from=%h",
                     recv_en, recv_from, exp_en, exp_from);
        end
        compared++;
        if (recv_addr !== exp_addr || recv_word !== exp_word) begin
            mismatched++;
            $display("[TB] FAIL multicast_data: addr=%h word=%h, required addr=%h word=%h",
                     recv_addr, recv_word, exp_addr, exp_word);
        end
    endtask

    task automatic test_enable_gating();
        repeat (4) begin
            randomize_data();
            send_en = '0;
            send_to = {$urandom, $urandom} | 64'h1;
            @(posedge clk); #1;
            compared++;
            if (recv_en !== '0 || recv_from !== '0 || recv_addr !== '0 || recv_word !== '0) begin
                mismatched++;
                $display("[TB] FAIL enable_gating: en=%h from=%h addr=%h word=%h, required all 0",
                         recv_en, recv_from, recv_addr, recv_word);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            send_en = N'($urandom);
            send_to = {$urandom, $urandom} & {$urandom, $urandom};
            randomize_data();
            model();
            @(posedge clk); #1;
            compared++;
            if (recv_en !== exp_en || recv_from !== exp_from) begin
                mismatched++;
                $display("[TB] FAIL random_grant_%0d: en=%h from=%h, required en=%h from=%h",
                         c, recv_en, recv_from, exp_en, exp_from);
            end
            compared++;
            if (recv_addr !== exp_addr || recv_word !== exp_word) begin
                mismatched++;
                $display("[TB] FAIL random_data_%0d: addr=%h word=%h, required addr=%h word=%h",
                         c, recv_addr, recv_word, exp_addr, exp_word);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        randomize_data();
        send_en          = 8'b0000_0010;
        send_to[1*N + 2] = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (recv_en !== 8'b0000_0100 || recv_from[2*N +: N] !== 8'b0000_0010) begin
            mismatched++;
            $display("[TB] FAIL async_pre: en=%h from=%h, required en=04 from2=02",
                     recv_en, recv_from);
        end
        #2 clr_n = 1'b0;
        #1;
        compared++;
        if (recv_en !== '0 || recv_from !== '0 || recv_addr !== '0 || recv_word !== '0) begin
            mismatched++;
            $display("[TB] FAIL async_clear: en=%h from=%h addr=%h word=%h, required all 0",
                     recv_en, recv_from, recv_addr, recv_word);
        end
        @(posedge clk); #1;
        compared++;
        if (recv_en !== '0 || recv_from !== '0) begin
            mismatched++;
            $display("[TB] FAIL async_hold: en=%h from=%h, required 0", recv_en, recv_from);
        end
        clr_n = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (recv_en !== 8'b0000_0100 || recv_word[2*W +: W] !== send_word[1*W +: W]) begin
            mismatched++;
            $display("[TB] FAIL async_resume: en=%h word2=%h, required en=04 word2=%h",
                     recv_en, recv_word[2*W +: W], send_word[1*W +: W]);
        end
    endtask

    initial begin
        clr_n = 1'b0;
        clear_inputs();
        test_reset();
        test_one_to_one();
        test_conflict();
        test_multicast();
        test_enable_gating();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/interconn.md
Name: interconn

Overview:
- N-port crossbar between MVUs: each source port i may write one (address, word) pair per cycle to any subset of destination ports.
- Each destination receives the registered word, address, a valid strobe and a one-hot source ID.
- Sits between the MVU write-back paths and the MVU memory write ports.
- No buffering, no backpressure: a transfer that loses arbitration is dropped.

Parameters:
- N, 8, number of MVU ports (sources = destinations = N).
- W, 64, data word width.
- BADDR, 15, memory address width.

Ports:
- clk  input  1  clock; all state on rising edge.
- clr_n  input  1  asynchronous active-low reset.
- send_to  input  N*N  destination select; bit [i*N+j] = source i targets destination j.
- send_en  input  N  bit i = source i has a valid transfer this cycle.
- send_addr  input  N*BADDR  slice [i*BADDR +: BADDR] = address from source i.
- send_word  input  N*W  slice [i*W +: W] = data from source i.
- recv_from  output  N*N  slice [j*N +: N] = one-hot source index delivered to destination j.
- recv_en  output  N  bit j = destination j holds a valid transfer.
- recv_addr  output  N*BADDR  slice [j*BADDR +: BADDR] = address delivered to j.
- recv_word  output  N*W  slice [j*W +: W] = word delivered to j.

Behaviour:
- Reset: while clr_n=0, all outputs are 0 (recv_en, recv_from, recv_addr, recv_word), independent of clk. Asserting reset mid-transfer discards it.
- Request: req[j][i] = send_en[i] & send_to[i*N+j]. send_to bits of a source with send_en=0 are ignored.
- Arbitration per destination j: fixed priority, lowest source index wins. Losing requests are dropped with no indication.
- Registering: on each rising edge, for each destination j:
  - If some request is present: recv_en[j]=1, recv_from slice = one-hot(winner), recv_addr/recv_word = winner's send_addr/send_word.
  - If no request: recv_en[j]=0 and recv_from/recv_addr/recv_word slices = 0.
- Latency: exactly 1 cycle. Inputs sampled at edge k appear on outputs after edge k and stay stable until edge k+1.
- Throughput: one transfer per destination per cycle. Independent destinations are served in parallel.
- Multicast: one source may set several send_to bits; every targeted destination whose arbitration that source wins receives the same addr/word.
- Self-send (i==j) is legal and routed like any other pair.
- Back-to-back: consecutive cycles with different targets produce consecutive independent results; there is no hold or merge.
- No internal state beyond the output registers.

Decomposition:
- Shared package holds the default constants (MVU count, data width, address width) used by interconn and the MVU top.
- One natural sub-module: interconn_port. Instantiated N times, one per destination. It contains:
  - the N-bit request vector,
  - the fixed-priority one-hot arbiter,
  - the addr/word AND-OR mux,
  - the output registers.
- interconn itself only does the request transposition and the generate loop.

Test Plan:
- Reset: hold clr_n=0 for 10 cycles with random inputs -> all outputs 0. Release clr_n with send_en=0 -> outputs stay 0.
- All 1-to-1 pairs: for every i≠j (56 cases at N=8), send_en=1<<i, send_to=1<<(i*N+j), addr=7, word=64'hdeadbeefdeadbeef, one cycle each. After the next edge:
  - recv_en[j]=1, recv_addr slice j=7, recv_word slice j=deadbeefdeadbeef, recv_from slice j=1<<i;
  - all other destinations show recv_en=0.
- Conflict: sources 2 and 5 both target destination 3 (addr 1/2, words 'h11/'h22) -> dest 3 gets from=1<<2, addr=1, word='h11; source 5's transfer is dropped.
- Multicast + parallel: source 0 targets dests 1,4; source 6 targets dest 7 -> dests 1 and 4 both show source 0's data with from=1<<0; dest 7 shows source 6's data; the others are idle.
- Enable gating: send_to nonzero with send_en=0 -> all recv_en=0 and all slices 0 after the next edge.
- Async reset mid-stream: drop clr_n between edges during an active transfer -> outputs clear immediately, without waiting for a clock edge.
